// File: rtl/mips_run_controller.sv
// -----------------------------------------------------------------------------
// mips_run_controller
//
// Run sequencer for the mips_cpu_harvard core. A single start/done handshake
// resets the CPU for RESET_CYCLES enabled edges, lets it run, detects halt
// (CPU inactive or fetch from HALT_ADDRESS), latches register_v0 and the RUN
// cycle count, and aborts programs that never halt after TIMEOUT_CYCLES.
//
// Ports:
//   clk               in   system clock, rising-edge active
//   reset             in   asynchronous active-high controller reset
//   start             in   run request, sampled only in IDLE
//   abort             in   cancel the run in HOLD_RESET or RUN
//   cpu_active        in   CPU active output
//   cpu_instr_address in   CPU instruction fetch address
//   cpu_register_v0   in   CPU register v0
//   cpu_reset         out  drives CPU reset
//   cpu_clk_enable    out  drives CPU clk_enable
//   busy              out  high in HOLD_RESET and RUN
//   done              out  one-cycle completion pulse
//   timed_out         out  last run ended by timeout
//   result            out  register_v0 latched at halt
//   cycle_count       out  RUN cycles of the current or last run
// -----------------------------------------------------------------------------
module mips_run_controller #(
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] HALT_ADDRESS   = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        cpu_active,
  input  logic [31:0] cpu_instr_address,
  input  logic [31:0] cpu_register_v0,
  output logic        cpu_reset,
  output logic        cpu_clk_enable,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] result,
  output logic [31:0] cycle_count
);

  localparam int unsigned   RCW         = $clog2(RESET_CYCLES + 1);
  localparam logic [RCW-1:0] RST_LAST   = RCW'(RESET_CYCLES - 1);
  localparam logic [RCW-1:0] RST_ONE    = RCW'(1);
  localparam logic [31:0]    TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_HOLD_RESET = 2'd1,
    S_RUN        = 2'd2,
    S_DONE       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [31:0]      cycle_count_q, cycle_count_d;
  logic [31:0]      result_q, result_d;
  logic             timed_out_q, timed_out_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             cpu_clk_enable_q, cpu_clk_enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [31:0]      cnt_inc_s;
  logic             halt_s;

  // The halt condition is masked on the first RUN edge while the CPU leaves reset.
  assign cnt_inc_s = cycle_count_q + 32'd1;
  assign halt_s    = (cycle_count_q != 32'd0) &&
                     ((cpu_active == 1'b0) || (cpu_instr_address == HALT_ADDRESS));

  // Next-state and datapath update logic.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    result_d      = result_q;
    timed_out_d   = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_HOLD_RESET;
          cycle_count_d = 32'd0;
          timed_out_d   = 1'b0;
          rst_cnt_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD_RESET: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_ONE;
        end
      end
      S_RUN: begin
        // Abort wins over halt and timeout and leaves the count untouched.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cycle_count_d = cnt_inc_s;
          if (halt_s) begin
            result_d = cpu_register_v0;
            state_d  = S_DONE;
          end else if (cnt_inc_s == TIMEOUT_VAL) begin
            timed_out_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from the next state so outputs can be registered.
  always_comb begin
    cpu_reset_d      = 1'b0;
    cpu_clk_enable_d = 1'b0;
    busy_d           = 1'b0;
    done_d           = 1'b0;
    case (state_d)
      S_IDLE: begin
        cpu_reset_d = 1'b0;
      end
      S_HOLD_RESET: begin
        cpu_reset_d      = 1'b1;
        cpu_clk_enable_d = 1'b1;
        busy_d           = 1'b1;
      end
      S_RUN: begin
        cpu_clk_enable_d = 1'b1;
        busy_d           = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      rst_cnt_q        <= '0;
      cycle_count_q    <= 32'd0;
      result_q         <= 32'd0;
      timed_out_q      <= 1'b0;
      cpu_reset_q      <= 1'b0;
      cpu_clk_enable_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      rst_cnt_q        <= rst_cnt_d;
      cycle_count_q    <= cycle_count_d;
      result_q         <= result_d;
      timed_out_q      <= timed_out_d;
      cpu_reset_q      <= cpu_reset_d;
      cpu_clk_enable_q <= cpu_clk_enable_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign cpu_reset      = cpu_reset_q;
  assign cpu_clk_enable = cpu_clk_enable_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timed_out      = timed_out_q;
  assign result         = result_q;
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_run_controller
//
// Randomized scoreboard bench. A small CPU model counts enabled non-reset
// edges and raises its halt indication from a chosen RUN cycle onward. For
// every run the expected completion is derived arithmetically and queued;
// a monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_mips_run_controller;

  localparam int RC = 2;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_register_v0;
  logic        cpu_reset;
  logic        cpu_clk_enable;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [31:0] result;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  mips_run_controller #(
    .RESET_CYCLES  (RC),
    .TIMEOUT_CYCLES(TO),
    .HALT_ADDRESS  (32'h00000000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .cpu_active       (cpu_active),
    .cpu_instr_address(cpu_instr_address),
    .cpu_register_v0  (cpu_register_v0),
    .cpu_reset        (cpu_reset),
    .cpu_clk_enable   (cpu_clk_enable),
    .busy             (busy),
    .done             (done),
    .timed_out        (timed_out),
    .result           (result),
    .cycle_count      (cycle_count)
  );

  always #5 clk = ~clk;

  // CPU model: halts (active low or fetch from 0) from RUN cycle m_halt_at onward.
  int          m_halt_at  = 0;
  int          m_kind     = 0;
  int          m_abort_at = 0;
  logic [31:0] m_v0       = 32'd0;
  logic        abort_force = 1'b0;
  logic [31:0] ncyc = 32'd0;
  logic        run_ph;
  logic        halt_show;

  always @(posedge clk) begin
    if (cpu_clk_enable) begin
      if (cpu_reset) ncyc <= 32'd0;
      else           ncyc <= ncyc + 32'd1;
    end
  end

  assign run_ph            = cpu_clk_enable && !cpu_reset;
  assign halt_show         = (m_halt_at != 0) && (int'(ncyc) + 1 >= m_halt_at);
  assign cpu_active        = !(halt_show && m_kind == 0);
  assign cpu_instr_address = (halt_show && m_kind == 1) ? 32'h00000000
                                                        : (32'hBFC00000 + (ncyc << 2));
  assign cpu_register_v0   = m_v0;
  assign abort             = abort_force ||
                             (run_ph && m_abort_at != 0 && int'(ncyc) + 1 == m_abort_at);

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] cnt;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] exp_result = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no run expected at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_result", result, mon_e.res);
        chk("done_cycle_count", cycle_count, mon_e.cnt);
        chk("done_timed_out", {31'd0, timed_out}, {31'd0, mon_e.tmo});
        chk("done_clk_enable", {31'd0, cpu_clk_enable}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
      end
    end
  end

  // One run: h = halt RUN cycle (0 = never), ab = abort RUN cycle (0 = none).
  task automatic do_run(input int h, input int kind, input logic [31:0] v0,
                        input int ab, input bit hold);
    int  eff;
    bit  halted;
    int  end_cyc;
    int  exp_lat;
    int  lat;
    bit  fin;
    @(negedge clk);
    eff     = (h == 0) ? 0 : ((h < 2) ? 2 : h);
    halted  = (h != 0) && (eff <= TO);
    end_cyc = halted ? eff : TO;
    m_halt_at  = h;
    m_kind     = kind;
    m_v0       = v0;
    m_abort_at = ab;
    if (ab != 0) begin
      exp_lat = RC + ab;
    end else begin
      exp_lat = RC + end_cyc;
      sb_q.push_back('{res: (halted ? v0 : exp_result), cnt: 32'(end_cyc), tmo: !halted});
      if (halted) exp_result = v0;
    end
    start = 1'b1;
    @(negedge clk);
    chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_timed_out_clr", {31'd0, timed_out}, 32'd0);
    chk("start_count_clr", cycle_count, 32'd0);
    if (!hold) start = 1'b0;
    lat = 1;
    fin = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      lat++;
    end
    start = 1'b0;
    chk("run_finished", {31'd0, fin}, 32'd1);
    chk("run_latency", 32'(lat), 32'(exp_lat));
    chk("end_clk_enable", {31'd0, cpu_clk_enable}, 32'd0);
    if (ab != 0) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_count", cycle_count, 32'(ab - 1));
      chk("abort_result", result, exp_result);
      chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    end else begin
      chk("done_pulse", {31'd0, done}, 32'd1);
    end
    @(negedge clk);
    m_abort_at = 0;
    chk("idle_done_low", {31'd0, done}, 32'd0);
    chk("idle_busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int h;
    int kind;
    int ab;
    int eff;
    int endc;
    // Asynchronous reset takes effect before any clock edge.
    #2 reset = 1'b1;
    #2;
    chk("reset_flags", {27'd0, cpu_reset, cpu_clk_enable, busy, done, timed_out}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_count", cycle_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_run(4, 0, 32'd1, 0, 1'b0);            // nominal
    do_run(0, 0, 32'hDEAD0001, 0, 1'b0);     // timeout, result unchanged
    do_run(0, 0, 32'h12345678, 6, 1'b0);     // abort at cycle_count 5
    do_run(1, 0, 32'hA5A5A5A5, 0, 1'b0);     // first-cycle mask
    do_run(20, 1, 32'h0BADF00D, 0, 1'b0);    // halt ties with timeout
    do_run(5, 1, 32'h00000777, 0, 1'b1);     // start held through run

    // start together with abort in IDLE does not start a run.
    @(negedge clk);
    start = 1'b1;
    abort_force = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort_force = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    chk("start_abort_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    // abort during HOLD_RESET.
    m_halt_at = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort_force = 1'b1;
    @(negedge clk);
    abort_force = 1'b0;
    chk("hold_abort_busy", {31'd0, busy}, 32'd0);
    chk("hold_abort_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("hold_abort_result", result, exp_result);

    for (int i = 0; i < 40; i++) begin
      h    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 25));
      kind = int'($urandom_range(0, 1));
      eff  = (h == 0) ? 0 : ((h < 2) ? 2 : h);
      endc = (h != 0 && eff <= TO) ? eff : TO;
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, endc)) : 0;
      do_run(h, kind, $urandom, ab, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of HOLD_RESET, between edges.
    @(negedge clk);
    m_halt_at = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midreset_flags", {27'd0, cpu_reset, cpu_clk_enable, busy, done, timed_out}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_count", cycle_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_result = 32'd0;
    do_run(3, 0, 32'h00000042, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_run_controller.md
# mips_run_controller

Run sequencer for the `mips_cpu_harvard` core and its data memory. It drives the CPU's `reset` and `clk_enable` to reset the core and then release it, and it watches `active` and `instr_address` to detect program halt. At halt it latches `register_v0` and the run's cycle count, and it aborts runaway programs with a timeout. It sits between a bench or host and the CPU, so a whole program run becomes one start/done handshake.

## Interface
Parameters:
- `RESET_CYCLES`, default 2: number of cycles the CPU is held in reset. Must be ≥1.
- `TIMEOUT_CYCLES`, default 1000: maximum number of RUN cycles before the run is aborted. Must be ≥2.
- `HALT_ADDRESS`, default 32'h00000000: fetch address that counts as program halt.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high controller reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `abort`  in  1  cancel the run in progress.
- `cpu_active`  in  1  CPU `active` output.
- `cpu_instr_address`  in  32  CPU `instr_address` output.
- `cpu_register_v0`  in  32  CPU `register_v0` output.
- `cpu_reset`  out  1  drives CPU `reset`.
- `cpu_clk_enable`  out  1  drives CPU `clk_enable`.
- `busy`  out  1  high in HOLD_RESET and RUN.
- `done`  out  1  one-cycle completion pulse.
- `timed_out`  out  1  the last run ended by timeout.
- `result`  out  32  `register_v0` latched at halt.
- `cycle_count`  out  32  number of RUN cycles in the current or last run.

## Operation
- All outputs are registered Moore outputs decoded from the state, with the datapath registers latched on edges.
- Asynchronous reset, effective immediately without a clock edge, sets:
  - state to IDLE;
  - `cpu_reset`=0, `cpu_clk_enable`=0;
  - `busy`=0, `done`=0, `timed_out`=0;
  - `result`=0, `cycle_count`=0.
- IDLE state:
  - Outputs: `cpu_reset`=0, `cpu_clk_enable`=0. The CPU is frozen and its state can be inspected.
  - `start`=1 with `abort`=0 moves to HOLD_RESET. On the same edge, `cycle_count`, `timed_out` and the reset counter are cleared.
  - `start`=1 with `abort`=1 stays in IDLE.
- HOLD_RESET state:
  - Outputs: `cpu_reset`=1, `cpu_clk_enable`=1, `busy`=1.
  - Lasts exactly RESET_CYCLES cycles, then moves to RUN.
- RUN state:
  - Outputs: `cpu_reset`=0, `cpu_clk_enable`=1, `busy`=1.
  - Every edge in RUN increments `cycle_count`.
  - The halt condition is (`cpu_active`==0 OR `cpu_instr_address`==HALT_ADDRESS).
  - The halt condition is ignored on the first RUN edge (`cycle_count`==0), because the CPU is just leaving reset.
  - Halt: latch `result`←`cpu_register_v0`, leave `timed_out`=0, go to DONE.
  - Timeout: if there is no halt and the incremented `cycle_count`==TIMEOUT_CYCLES, set `timed_out`=1, leave `result` unchanged, go to DONE.
  - If halt and timeout occur on the same edge, halt wins and `timed_out`=0.
- DONE state:
  - Outputs: `done`=1, `cpu_clk_enable`=0, `cpu_reset`=0, `busy`=0.
  - Always returns to IDLE on the next edge.
- `abort`:
  - In HOLD_RESET or RUN, `abort` moves to IDLE on the next edge. No `done` pulse is produced, `result` is unchanged, and `cycle_count` holds its value.
  - `abort` takes priority over halt and timeout on the same edge.
  - `abort` is ignored in DONE.
- `start` is ignored outside IDLE.
- `timed_out`, `result` and `cycle_count` hold their values until the next accepted `start`.
- Width rules:
  - `cycle_count` is 32 bits.
  - The reset counter is $clog2(RESET_CYCLES+1) bits.
  - The TIMEOUT_CYCLES comparison is made at 32 bits.

## Timing
- `start` accepted at edge N: `cpu_reset`=1 and `busy`=1 during cycle N+1.
- First RUN cycle: N+RESET_CYCLES+1. The CPU therefore sees `reset` high on exactly RESET_CYCLES enabled edges.
- Halt or timeout detected at edge M: `done`=1 and `cpu_clk_enable`=0 during cycle M+1, with `result`, `timed_out` and `cycle_count` valid at the same time.
- Edge M+1: back to IDLE. A new `start` can be accepted at edge M+2.
- The CPU receives no enabled edge after edge M, so its state at halt is preserved.
- Start-to-done minimum latency: RESET_CYCLES+2 edges.

## Test plan
- Nominal run: RESET_CYCLES=2; a CPU model jumps to 0 and drops `active` at RUN cycle 4 with v0=1. Required: `done` pulses once; `result`=1, `cycle_count`=4, `timed_out`=0; `cpu_clk_enable`=0 from the `done` cycle.
- Timeout: TIMEOUT_CYCLES=20 and the CPU never halts. Required: `done` with `timed_out`=1, `cycle_count`=20, `result` unchanged (0); a following accepted `start` clears `timed_out` to 0.
- Abort in RUN at `cycle_count`=5. Required: IDLE next cycle, `busy`=0, no `done` pulse, `cpu_clk_enable`=0, `result` unchanged, `cycle_count`=5.
- Asynchronous `reset` asserted mid-HOLD_RESET, between clock edges. Required: all outputs at their reset values immediately; `cpu_reset`=0.
- Corner priorities:
  - `start` and `abort` together in IDLE: stays in IDLE.
  - `start` held high through RUN and DONE: exactly one run.
  - Halt on the same edge as timeout (halt at RUN cycle 20, TIMEOUT_CYCLES=20): `timed_out`=0 and `result` latched.
- First-cycle mask: `cpu_active`=0 on the first RUN edge does not halt the run; `active`=0 on the second RUN edge halts it with `cycle_count`=2.
